pdo_cache_writer: RTL and testbench

//  Write side of the stereo sample cache. Takes one stereo sample per SampleValid pulse and

---
 rtl/pdo_cache_writer_if.sv | 36 +++
 rtl/pdo_cache_writer.sv | 123 ++++++++++++
 tb/tb_pdo_cache_writer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdo_cache_writer_if.sv
// rtl/pdo_cache_writer_if.sv - sample input, DPRAM write bus and frame handshake of the cache writer
// Optional drop counter signal present when CACHE_DROP_COUNT_EN is defined.
interface pdo_cache_writer_if #(
    parameter int BW_DPRAM = 12,
    parameter int BW_DATA  = 16
);
    logic                sample_valid;
    logic [BW_DATA-1:0]  data_l;
    logic [BW_DATA-1:0]  data_r;
    logic                wr_en;
    logic [BW_DPRAM-1:0] wr_addr;
    logic [BW_DATA-1:0]  wr_data;
    logic                frame_ready;
    logic                frame_bank;
    logic                frame_ack;
    logic                overrun;
`ifdef CACHE_DROP_COUNT_EN
    logic [7:0]          drop_count;
`endif

    modport master (
`ifdef CACHE_DROP_COUNT_EN
        output drop_count,
`endif
        input  sample_valid, data_l, data_r, frame_ack,
        output wr_en, wr_addr, wr_data, frame_ready, frame_bank, overrun
    );

    modport slave (
`ifdef CACHE_DROP_COUNT_EN
        input  drop_count,
`endif
        output sample_valid, data_l, data_r, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_ready, frame_bank, overrun
    );
endinterface

// File: rtl/pdo_cache_writer.sv
// rtl/pdo_cache_writer.sv - stereo sample writer into a ping-pong banked DPRAM with frame handshake
// Optional saturating drop counter enabled by defining CACHE_DROP_COUNT_EN.
module pdo_cache_writer #(
    parameter int BW_DPRAM = 12,
    parameter int BW_DATA  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pdo_cache_writer_if.master bus
);
    localparam int IW = BW_DPRAM - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR_L = 2'd1;
    localparam logic [1:0] S_WR_R = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               bank_q, bank_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [BW_DATA-1:0] cap_l_q, cap_l_d;
    logic [BW_DATA-1:0] cap_r_q, cap_r_d;
    logic               ready_q, ready_d;
    logic               fbank_q, fbank_d;
    logic               ovr_q, ovr_d;
    logic               busy;
    logic               bank_done;

    assign busy      = (state_q == S_WR_L) || (state_q == S_WR_R);
    assign bank_done = (state_q == S_WR_R) && (&idx_q);

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        idx_d   = idx_q;
        cap_l_d = cap_l_q;
        cap_r_d = cap_r_q;
        ready_d = ready_q;
        fbank_d = fbank_q;
        // A strobe while a pair is in flight is dropped; the pair itself is untouched.
        ovr_d   = bus.sample_valid && busy;

        case (state_q)
            S_IDLE: begin
                if (bus.sample_valid) begin
                    cap_l_d = bus.data_l;
                    cap_r_d = bus.data_r;
                    state_d = S_WR_L;
                end
            end
            S_WR_L: state_d = S_WR_R;
            S_WR_R: begin
                idx_d   = idx_q + 1'b1;
                state_d = S_IDLE;
                if (&idx_q) begin
                    bank_d = ~bank_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion outranks a same-cycle ack, so that ack cannot cancel the new frame.
        if (bank_done) begin
            ready_d = 1'b1;
            fbank_d = bank_q;
            if (ready_q && !bus.frame_ack) begin
                ovr_d = 1'b1;
            end
        end else if (bus.frame_ack) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            bank_q  <= 1'b0;
            idx_q   <= '0;
            cap_l_q <= '0;
            cap_r_q <= '0;
            ready_q <= 1'b0;
            fbank_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            cap_l_q <= cap_l_d;
            cap_r_q <= cap_r_d;
            ready_q <= ready_d;
            fbank_q <= fbank_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.wr_en       = busy;
    assign bus.wr_addr     = busy ? {bank_q, idx_q, (state_q == S_WR_R)} : '0;
    assign bus.wr_data     = (state_q == S_WR_L) ? cap_l_q :
                             (state_q == S_WR_R) ? cap_r_q : '0;
    assign bus.frame_ready = ready_q;
    assign bus.frame_bank  = fbank_q;
    assign bus.overrun     = ovr_q;

`ifdef CACHE_DROP_COUNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (ovr_d && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_count = drop_q;
`endif
endmodule

// File: tb/tb_pdo_cache_writer.sv
// tb/tb_pdo_cache_writer.sv - randomized self-checking bench for pdo_cache_writer
// Reference model: queue of pending RAM writes plus frame-handshake bookkeeping.
module tb_pdo_cache_writer;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int VW = 1 + AW + DW + 3 + 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pdo_cache_writer_if #(.BW_DPRAM(AW), .BW_DATA(DW)) bus ();
    pdo_cache_writer #(.BW_DPRAM(AW), .BW_DATA(DW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    wr_t        pend[$];
    int         m_pos   = 0;
    logic       m_ready = 1'b0;
    logic       m_bank  = 1'b0;
    logic       m_ovr   = 1'b0;
    int         m_drops = 0;
    int         errors  = 0;
    int         checks  = 0;
    logic [VW-1:0] obs_v, exp_v;

    // Snapshot this cycle's outputs against the model, drive inputs, advance the model one clock.
    task automatic tick(input logic r, input logic sv, input logic [DW-1:0] l,
                        input logic [DW-1:0] rr, input logic ack);
        logic          e_en;
        logic          busy;
        logic          done;
        logic          nov;
        wr_t           f;
        wr_t           e;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        logic [7:0]    odc;
        logic [7:0]    edc;
        e_en = (pend.size() != 0);
        f    = e_en ? pend[0] : '0;
        oa   = e_en ? bus.wr_addr : {AW{1'b0}};
        od   = e_en ? bus.wr_data : {DW{1'b0}};
`ifdef CACHE_DROP_COUNT_EN
        odc  = bus.drop_count;
        edc  = 8'(m_drops);
`else
        odc  = 8'h00;
        edc  = 8'h00;
`endif
        obs_v = {bus.wr_en, oa, od, bus.frame_ready, bus.frame_bank, bus.overrun, odc};
        exp_v = {e_en, f.addr, f.data, m_ready, m_bank, m_ovr, edc};

        rst              = r;
        bus.sample_valid = sv;
        bus.data_l       = l;
        bus.data_r       = rr;
        bus.frame_ack    = ack;

        if (r) begin
            pend.delete();
            m_pos = 0; m_ready = 1'b0; m_bank = 1'b0; m_ovr = 1'b0; m_drops = 0;
        end else begin
            busy = e_en;
            done = 1'b0;
            nov  = 1'b0;
            if (busy) begin
                f = pend.pop_front();
                done = (f.addr[AW-2:0] == {(AW-1){1'b1}});
            end
            if (sv) begin
                if (busy) nov = 1'b1;
                else begin
                    e.addr = AW'(m_pos);     e.data = l;  pend.push_back(e);
                    e.addr = AW'(m_pos + 1); e.data = rr; pend.push_back(e);
                    m_pos = (m_pos + 2) % (1 << AW);
                end
            end
            if (done) begin
                if (m_ready && !ack) nov = 1'b1;
                m_ready = 1'b1;
                m_bank  = f.addr[AW-1];
            end else if (ack) begin
                m_ready = 1'b0;
            end
            m_ovr = nov;
            if (nov && m_drops < 255) m_drops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        tick(1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b1);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_ready, bus.frame_bank, bus.overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h rdy=%b bank=%b ovr=%b, want all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_ready, bus.frame_bank, bus.overrun);
        end
`ifdef CACHE_DROP_COUNT_EN
        checks++;
        if (bus.drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_dropcount: got %0d want 0", bus.drop_count);
        end
`endif
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL reset_model: got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_single();
        tick(1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b0);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 12'h000, 16'h1234}) begin
            errors++; $display("FAIL single_L: got en=%b addr=%h data=%h want 1 000 1234", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 12'h001, 16'hABCD}) begin
            errors++; $display("FAIL single_R: got en=%b addr=%h data=%h want 1 001 abcd", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_idle: got wr_en=%b want 0", bus.wr_en); end
        for (int j = 0; j < 2; j++) begin
            tick(1'b0, 1'b0, '0, '0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL single_model: got %h want %h", obs_v, exp_v); end
        end
    endtask

    task automatic test_fill_bank();
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        for (int p = 0; p < 1024; p++) begin
            logic [DW-1:0] l, r;
            l = DW'($urandom); r = DW'($urandom);
            for (int j = 0; j < 4; j++) begin
                tick(1'b0, (j == 0), l, r, 1'b0);
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL fill_model p=%0d: got %h want %h", p, obs_v, exp_v); end
                if (p == 1023 && j == 1) begin
                    checks++;
                    if ({bus.wr_en, bus.wr_addr, bus.frame_ready} !== {1'b1, 12'h7FF, 1'b0}) begin
                        errors++; $display("FAIL fill_last_R: got en=%b addr=%h rdy=%b want 1 7ff 0", bus.wr_en, bus.wr_addr, bus.frame_ready);
                    end
                end
                if (p == 1023 && j == 2) begin
                    checks++;
                    if ({bus.frame_ready, bus.frame_bank} !== 2'b10) begin
                        errors++; $display("FAIL fill_ready: got rdy=%b bank=%b want 1 0", bus.frame_ready, bus.frame_bank);
                    end
                end
            end
        end
        tick(1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
        checks++;
        if ({bus.wr_en, bus.wr_addr} !== {1'b1, 12'h800}) begin errors++; $display("FAIL bank1_L: got addr=%h want 800", bus.wr_addr); end
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if ({bus.wr_en, bus.wr_addr} !== {1'b1, 12'h801}) begin errors++; $display("FAIL bank1_R: got addr=%h want 801", bus.wr_addr); end
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL bank1_model: got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_consecutive();
        tick(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        tick(1'b0, 1'b1, 16'h3333, 16'h4444, 1'b0);
        checks++;
        if ({bus.overrun, bus.wr_data} !== {1'b1, 16'h2222}) begin
            errors++; $display("FAIL consec_drop: got ovr=%b data=%h want 1 2222", bus.overrun, bus.wr_data);
        end
        for (int j = 0; j < 3; j++) begin
            tick(1'b0, 1'b0, '0, '0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL consec_model: got %h want %h", obs_v, exp_v); end
        end
`ifdef CACHE_DROP_COUNT_EN
        checks++;
        if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL consec_dropcount: got %0d want 1", bus.drop_count); end
`endif
    endtask

    task automatic test_overwrite();
        checks++;
        if (bus.frame_ready !== 1'b1) begin errors++; $display("FAIL overwrite_pre: got rdy=%b want 1", bus.frame_ready); end
        for (int n = 0; n < 1100 && m_pos != 0; n++) begin
            logic [DW-1:0] l, r;
            l = DW'($urandom); r = DW'($urandom);
            for (int j = 0; j < 3; j++) begin
                tick(1'b0, (j == 0), l, r, 1'b0);
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL overwrite_model: got %h want %h", obs_v, exp_v); end
            end
        end
        checks++;
        if ({bus.frame_ready, bus.frame_bank, bus.overrun} !== 3'b111) begin
            errors++; $display("FAIL overwrite_frame: got rdy=%b bank=%b ovr=%b want 1 1 1", bus.frame_ready, bus.frame_bank, bus.overrun);
        end
    endtask

    task automatic test_ack_coincident();
        for (int n = 0; n < 1100 && m_pos != 12'h7FE; n++) begin
            logic [DW-1:0] l, r;
            l = DW'($urandom); r = DW'($urandom);
            for (int j = 0; j < 3; j++) begin
                tick(1'b0, (j == 0), l, r, 1'b0);
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL coinc_model: got %h want %h", obs_v, exp_v); end
            end
        end
        tick(1'b0, 1'b1, 16'hCAFE, 16'hBEEF, 1'b0);
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if ({bus.frame_ready, bus.frame_bank, bus.overrun} !== 3'b100) begin
            errors++; $display("FAIL coinc_frame: got rdy=%b bank=%b ovr=%b want 1 0 0", bus.frame_ready, bus.frame_bank, bus.overrun);
        end
    endtask

    task automatic test_ack_clear();
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if (bus.frame_ready !== 1'b0) begin errors++; $display("FAIL ack_clear: got rdy=%b want 0", bus.frame_ready); end
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if ({bus.frame_ready, bus.overrun} !== 2'b00) begin
            errors++; $display("FAIL ack_idle: got rdy=%b ovr=%b want 0 0", bus.frame_ready, bus.overrun);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 9000; c++) begin
            tick(1'b0, ($urandom_range(0, 2) == 0), DW'($urandom), DW'($urandom), ($urandom_range(0, 63) == 0));
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random_model c=%0d: got %h want %h", c, obs_v, exp_v); end
        end
    endtask

    task automatic test_reset_mid_pair();
        for (int j = 0; j < 3; j++) tick(1'b0, 1'b0, '0, '0, 1'b0);
        tick(1'b0, 1'b1, 16'h7777, 16'h8888, 1'b0);
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        checks++;
        if ({bus.wr_en, bus.frame_ready, bus.overrun} !== 3'b000) begin
            errors++; $display("FAIL midreset_state: got en=%b rdy=%b ovr=%b want 0 0 0", bus.wr_en, bus.frame_ready, bus.overrun);
        end
`ifdef CACHE_DROP_COUNT_EN
        checks++;
        if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL midreset_dropcount: got %0d want 0", bus.drop_count); end
`endif
        tick(1'b0, 1'b1, 16'h9999, 16'h6666, 1'b0);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 12'h000, 16'h9999}) begin
            errors++; $display("FAIL midreset_L: got en=%b addr=%h data=%h want 1 000 9999", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 12'h001, 16'h6666}) begin
            errors++; $display("FAIL midreset_R: got en=%b addr=%h data=%h want 1 001 6666", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL midreset_model: got %h want %h", obs_v, exp_v); end
    endtask

    initial begin
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.data_l = '0;
        bus.data_r = '0;
        bus.frame_ack = 1'b0;
        test_reset();
        test_single();
        test_fill_bank();
        test_consecutive();
        test_overwrite();
        test_ack_coincident();
        test_ack_clear();
        test_random();
        test_reset_mid_pair();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
